// File: rtl/continuous_monitoring_system_pkg.sv
// rtl/continuous_monitoring_system_pkg.sv - shared types and address map for the continuous monitoring system
// Purpose: trace-state encoding, control address map, WFI opcode and default sizes
//          shared by cms_trigger_ctrl and its sub-modules.
// Ports:   none (package).
package continuous_monitoring_system_pkg;

  localparam logic [31:0] WFI_INSTRUCTION      = 32'h10500073;
  localparam int          CLK_COUNTER_WIDTH    = 64;
  localparam int          DEFAULT_NUM_TRIGGERS = 4;
  localparam int          DEFAULT_NUM_RANGES   = 2;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    TRACING  = 2'd1,
    WFI_HALT = 2'd2
  } trace_state_e;

  // Fixed single-register addresses
  localparam logic [7:0] ADDR_START_EN    = 8'h00;
  localparam logic [7:0] ADDR_END_EN      = 8'h01;
  localparam logic [7:0] ADDR_RANGE_EN    = 8'h02;
  localparam logic [7:0] ADDR_WFI_STOPPED = 8'h03;
  localparam logic [7:0] ADDR_CLK_COUNTER = 8'h04;
  localparam logic [7:0] ADDR_FORCE       = 8'h05;

  // Indexed register banks: base + index, index in the low nibble
  localparam logic [7:0] BASE_START_ADDR  = 8'h10;
  localparam logic [7:0] BASE_END_ADDR    = 8'h20;
  localparam logic [7:0] BASE_RANGE_LO    = 8'h30;
  localparam logic [7:0] BASE_RANGE_HI    = 8'h40;
  localparam logic [7:0] BASE_HIT_COUNT   = 8'h50;

  localparam int FORCE_TRACING = 1;
  localparam int FORCE_STOPPED = 2;

endpackage

// File: rtl/cms_addr_range_match.sv
// rtl/cms_addr_range_match.sv - one enabled inclusive lo/hi address comparator
// Purpose: match = en & (lo <= pc <= hi), unsigned. A range with lo > hi can never match.
// Ports:   pc, lo, hi (XLEN) - address and range bounds; en - range enable;
//          match - combinational result.
module cms_addr_range_match
  import continuous_monitoring_system_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] hi,
  input  logic            en,
  output logic            match
);

  assign match = en & (pc >= lo) & (pc <= hi);

endmodule

// File: rtl/cms_trigger_ctrl.sv
// rtl/cms_trigger_ctrl.sv - start/end trigger pairs, monitored ranges and trace-enable FSM
// Purpose: decides per retired instruction whether it enters the trace FIFO.
// Optional: define CMS_TRIGGER_HIT_COUNT_EN for per-trigger saturating start-hit counters at 0x50+i.
// Ports:   clk, rst (async active-high)
//          ctrl_addr/ctrl_wdata/ctrl_wr_en/ctrl_rd_en - control write/read port
//          ctrl_rdata - registered read data, held until next read
//          pc/instr/pc_valid - retired instruction tap
//          trace_accept - combinational trace gate
//          trace_state, wfi_stopped, clk_counter - registered status
module cms_trigger_ctrl #(
  parameter int XLEN              = 64,
  parameter int NUM_TRIGGERS      = continuous_monitoring_system_pkg::DEFAULT_NUM_TRIGGERS,
  parameter int NUM_RANGES        = continuous_monitoring_system_pkg::DEFAULT_NUM_RANGES,
  parameter int CTRL_ADDR_WIDTH   = 8,
  parameter int CTRL_DATA_WIDTH   = 64,
  parameter int CLK_COUNTER_WIDTH = continuous_monitoring_system_pkg::CLK_COUNTER_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CTRL_ADDR_WIDTH-1:0]   ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0]   ctrl_wdata,
  input  logic                         ctrl_wr_en,
  input  logic                         ctrl_rd_en,
  output logic [CTRL_DATA_WIDTH-1:0]   ctrl_rdata,
  input  logic [XLEN-1:0]              pc,
  input  logic [31:0]                  instr,
  input  logic                         pc_valid,
  output logic                         trace_accept,
  output logic [1:0]                   trace_state,
  output logic                         wfi_stopped,
  output logic [CLK_COUNTER_WIDTH-1:0] clk_counter
);
  import continuous_monitoring_system_pkg::*;

  localparam int GW = CTRL_ADDR_WIDTH - 4;

  logic [NUM_TRIGGERS-1:0] start_en, end_en;
  logic [NUM_RANGES-1:0]   range_en;
  logic [XLEN-1:0]         start_addr [NUM_TRIGGERS];
  logic [XLEN-1:0]         end_addr   [NUM_TRIGGERS];
  logic [XLEN-1:0]         range_lo   [NUM_RANGES];
  logic [XLEN-1:0]         range_hi   [NUM_RANGES];

  trace_state_e state_q, state_d;

  // Address decode: high bits select a bank, low nibble indexes inside it
  logic [GW-1:0] addr_grp;
  logic [3:0]    addr_idx;
  assign addr_grp = ctrl_addr[CTRL_ADDR_WIDTH-1:4];
  assign addr_idx = ctrl_addr[3:0];

  logic sel_start_en, sel_end_en, sel_range_en, sel_wfi, sel_clk, sel_force;
  logic sel_start, sel_end, sel_lo, sel_hi;
  assign sel_start_en = ctrl_addr == CTRL_ADDR_WIDTH'(ADDR_START_EN);
  assign sel_end_en   = ctrl_addr == CTRL_ADDR_WIDTH'(ADDR_END_EN);
  assign sel_range_en = ctrl_addr == CTRL_ADDR_WIDTH'(ADDR_RANGE_EN);
  assign sel_wfi      = ctrl_addr == CTRL_ADDR_WIDTH'(ADDR_WFI_STOPPED);
  assign sel_clk      = ctrl_addr == CTRL_ADDR_WIDTH'(ADDR_CLK_COUNTER);
  assign sel_force    = ctrl_addr == CTRL_ADDR_WIDTH'(ADDR_FORCE);
  assign sel_start    = addr_grp == GW'(BASE_START_ADDR[7:4]);
  assign sel_end      = addr_grp == GW'(BASE_END_ADDR[7:4]);
  assign sel_lo       = addr_grp == GW'(BASE_RANGE_LO[7:4]);
  assign sel_hi       = addr_grp == GW'(BASE_RANGE_HI[7:4]);

  logic wr_force_trace, wr_force_stop, wr_arm, wr_wfi_clear;
  assign wr_force_trace = ctrl_wr_en & sel_force & (ctrl_wdata == CTRL_DATA_WIDTH'(FORCE_TRACING));
  assign wr_force_stop  = ctrl_wr_en & sel_force & (ctrl_wdata == CTRL_DATA_WIDTH'(FORCE_STOPPED));
  assign wr_arm         = ctrl_wr_en & sel_start_en & (ctrl_wdata[NUM_TRIGGERS-1:0] != '0);
  assign wr_wfi_clear   = ctrl_wr_en & sel_wfi & (ctrl_wdata == '0);

  // Configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_en <= '0;
      end_en   <= '0;
      range_en <= '0;
      for (int i = 0; i < NUM_TRIGGERS; i++) begin
        start_addr[i] <= '0;
        end_addr[i]   <= '0;
      end
      for (int i = 0; i < NUM_RANGES; i++) begin
        range_lo[i] <= '0;
        range_hi[i] <= '0;
      end
    end else if (ctrl_wr_en) begin
      if (sel_start_en) start_en <= ctrl_wdata[NUM_TRIGGERS-1:0];
      if (sel_end_en)   end_en   <= ctrl_wdata[NUM_TRIGGERS-1:0];
      if (sel_range_en) range_en <= ctrl_wdata[NUM_RANGES-1:0];
      for (int i = 0; i < NUM_TRIGGERS; i++) begin
        if (sel_start && addr_idx == 4'(i)) start_addr[i] <= XLEN'(ctrl_wdata);
        if (sel_end   && addr_idx == 4'(i)) end_addr[i]   <= XLEN'(ctrl_wdata);
      end
      for (int i = 0; i < NUM_RANGES; i++) begin
        if (sel_lo && addr_idx == 4'(i)) range_lo[i] <= XLEN'(ctrl_wdata);
        if (sel_hi && addr_idx == 4'(i)) range_hi[i] <= XLEN'(ctrl_wdata);
      end
    end
  end

  // Trigger hits
  logic [NUM_TRIGGERS-1:0] start_match, end_match;
  logic start_hit, end_hit, wfi_seen;
  always_comb begin
    start_match = '0;
    end_match   = '0;
    for (int i = 0; i < NUM_TRIGGERS; i++) begin
      start_match[i] = start_en[i] & (pc == start_addr[i]);
      end_match[i]   = end_en[i] & (pc == end_addr[i]);
    end
  end
  assign start_hit = pc_valid & (|start_match);
  assign end_hit   = pc_valid & (|end_match);
  assign wfi_seen  = pc_valid & (instr == WFI_INSTRUCTION);

  // Range gate: with no range enabled every address is in range
  logic [NUM_RANGES-1:0] range_match;
  logic in_range;
  for (genvar g = 0; g < NUM_RANGES; g++) begin : g_range
    cms_addr_range_match #(.XLEN(XLEN)) u_match (
      .pc    (pc),
      .lo    (range_lo[g]),
      .hi    (range_hi[g]),
      .en    (range_en[g]),
      .match (range_match[g])
    );
  end
  assign in_range = (range_en == '0) | (|range_match);

  // Trace-enable FSM. Priority outside WFI_HALT: WFI instruction, then
  // state-changing ctrl writes (FORCE, arm), then trigger hits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= TRACING;
      wfi_stopped <= 1'b0;
    end else begin
      state_q     <= state_d;
      wfi_stopped <= state_d == WFI_HALT;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WFI_HALT: begin
        if (wr_wfi_clear) state_d = (start_en != '0) ? STOPPED : TRACING;
      end
      default: begin
        if (wfi_seen)                                 state_d = WFI_HALT;
        else if (wr_force_trace)                      state_d = TRACING;
        else if (wr_force_stop)                       state_d = STOPPED;
        else if (wr_arm && state_q == TRACING)        state_d = STOPPED;
        else if (state_q == TRACING && end_hit)       state_d = STOPPED;
        else if (state_q == STOPPED && start_hit)     state_d = TRACING;
      end
    endcase
  end

  assign trace_state  = state_q;
  // The start instruction is traced from STOPPED; the end instruction is traced because state is still TRACING
  assign trace_accept = pc_valid & in_range &
                        ((state_q == TRACING) | ((state_q == STOPPED) & start_hit));

  // Free-running counter, frozen while halted on WFI
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          clk_counter <= '0;
    else if (ctrl_wr_en && sel_clk)   clk_counter <= CLK_COUNTER_WIDTH'(ctrl_wdata);
    else if (state_q != WFI_HALT)     clk_counter <= clk_counter + CLK_COUNTER_WIDTH'(1);
  end

`ifdef CMS_TRIGGER_HIT_COUNT_EN
  logic        sel_hit;
  logic [31:0] hit_cnt [NUM_TRIGGERS];
  assign sel_hit = addr_grp == GW'(BASE_HIT_COUNT[7:4]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TRIGGERS; i++) hit_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TRIGGERS; i++) begin
        if (ctrl_wr_en && sel_hit && addr_idx == 4'(i))
          hit_cnt[i] <= '0;
        else if (pc_valid && start_match[i] && state_q != WFI_HALT && hit_cnt[i] != '1)
          hit_cnt[i] <= hit_cnt[i] + 32'd1;
      end
    end
  end
`endif

  // Read mux; unmapped addresses read as zero
  logic [CTRL_DATA_WIDTH-1:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    if (sel_start_en) rd_mux = CTRL_DATA_WIDTH'(start_en);
    if (sel_end_en)   rd_mux = CTRL_DATA_WIDTH'(end_en);
    if (sel_range_en) rd_mux = CTRL_DATA_WIDTH'(range_en);
    if (sel_wfi)      rd_mux = CTRL_DATA_WIDTH'(wfi_stopped);
    if (sel_clk)      rd_mux = CTRL_DATA_WIDTH'(clk_counter);
    for (int i = 0; i < NUM_TRIGGERS; i++) begin
      if (sel_start && addr_idx == 4'(i)) rd_mux = CTRL_DATA_WIDTH'(start_addr[i]);
      if (sel_end   && addr_idx == 4'(i)) rd_mux = CTRL_DATA_WIDTH'(end_addr[i]);
`ifdef CMS_TRIGGER_HIT_COUNT_EN
      if (sel_hit   && addr_idx == 4'(i)) rd_mux = CTRL_DATA_WIDTH'(hit_cnt[i]);
`endif
    end
    for (int i = 0; i < NUM_RANGES; i++) begin
      if (sel_lo && addr_idx == 4'(i)) rd_mux = CTRL_DATA_WIDTH'(range_lo[i]);
      if (sel_hi && addr_idx == 4'(i)) rd_mux = CTRL_DATA_WIDTH'(range_hi[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             ctrl_rdata <= '0;
    else if (ctrl_rd_en) ctrl_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_cms_trigger_ctrl.sv
// tb/tb_cms_trigger_ctrl.sv - self-checking bench for cms_trigger_ctrl
module tb_cms_trigger_ctrl;
  localparam int NT = 4;
  localparam int NR = 2;
  localparam logic [31:0] WFI = 32'h10500073;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ctrl_addr;
  logic [63:0] ctrl_wdata, ctrl_rdata;
  logic        ctrl_wr_en, ctrl_rd_en;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        pc_valid, trace_accept, wfi_stopped;
  logic [1:0]  trace_state;
  logic [63:0] clk_counter;

  cms_trigger_ctrl dut (
    .clk(clk), .rst(rst), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_wr_en(ctrl_wr_en), .ctrl_rd_en(ctrl_rd_en), .ctrl_rdata(ctrl_rdata),
    .pc(pc), .instr(instr), .pc_valid(pc_valid), .trace_accept(trace_accept),
    .trace_state(trace_state), .wfi_stopped(wfi_stopped), .clk_counter(clk_counter)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int checks = 0;
  int passes = 0;

  // Reference model: 0=stopped 1=tracing 2=halted on WFI
  int          m_state = 1;
  logic [63:0] m_cnt = '0, m_rdata = '0;
  logic [15:0] m_sen = '0, m_een = '0, m_ren = '0;
  logic [63:0] m_sa [16], m_ea [16], m_lo [16], m_hi [16], m_hits [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit m_start_hit(input logic [63:0] a);
    for (int i = 0; i < NT; i++) if (m_sen[i] && a == m_sa[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_end_hit(input logic [63:0] a);
    for (int i = 0; i < NT; i++) if (m_een[i] && a == m_ea[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_in_range(input logic [63:0] a);
    if (m_ren == 0) return 1'b1;
    for (int i = 0; i < NR; i++) if (m_ren[i] && m_lo[i] <= a && a <= m_hi[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_read(input logic [7:0] a);
    logic [3:0] ix;
    bit t_ok, r_ok;
    ix = a[3:0];
    t_ok = int'(ix) < NT;
    r_ok = int'(ix) < NR;
    case (a[7:4])
      4'h0: case (ix)
              4'h0: return 64'(m_sen);
              4'h1: return 64'(m_een);
              4'h2: return 64'(m_ren);
              4'h3: return (m_state == 2) ? 64'd1 : 64'd0;
              4'h4: return m_cnt;
              default: return 64'd0;
            endcase
      4'h1: return t_ok ? m_sa[ix] : 64'd0;
      4'h2: return t_ok ? m_ea[ix] : 64'd0;
      4'h3: return r_ok ? m_lo[ix] : 64'd0;
      4'h4: return r_ok ? m_hi[ix] : 64'd0;
`ifdef CMS_TRIGGER_HIT_COUNT_EN
      4'h5: return t_ok ? m_hits[ix] : 64'd0;
`endif
      default: return 64'd0;
    endcase
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [63:0] d);
    logic [3:0] ix;
    ix = a[3:0];
    case (a[7:4])
      4'h0: begin
        if (ix == 4'h0) m_sen = 16'(d[NT-1:0]);
        if (ix == 4'h1) m_een = 16'(d[NT-1:0]);
        if (ix == 4'h2) m_ren = 16'(d[NR-1:0]);
      end
      4'h1: if (int'(ix) < NT) m_sa[ix] = d;
      4'h2: if (int'(ix) < NT) m_ea[ix] = d;
      4'h3: if (int'(ix) < NR) m_lo[ix] = d;
      4'h4: if (int'(ix) < NR) m_hi[ix] = d;
      default: ;
    endcase
  endtask

  task automatic drive(input logic v, input logic [63:0] p, input logic [31:0] ins,
                       input logic w, input logic r, input logic [7:0] a, input logic [63:0] d);
    pc_valid = v; pc = p; instr = ins;
    ctrl_wr_en = w; ctrl_rd_en = r; ctrl_addr = a; ctrl_wdata = d;
  endtask

  // Check the combinational gate, advance the model over one edge, check registered outputs
  task automatic tick(input string tag);
    bit sh, eh, acc, wr_force1, wr_force2, wr_arm;
    int ns;
    logic [63:0] rv;
    #2;
    sh  = pc_valid && m_start_hit(pc);
    eh  = pc_valid && m_end_hit(pc);
    acc = pc_valid && m_in_range(pc) && (m_state == 1 || (m_state == 0 && sh));
    chk({tag, ".accept"}, 64'(trace_accept), 64'(acc));
    rv = m_read(ctrl_addr);
    wr_force1 = ctrl_wr_en && ctrl_addr == 8'h05 && ctrl_wdata == 64'd1;
    wr_force2 = ctrl_wr_en && ctrl_addr == 8'h05 && ctrl_wdata == 64'd2;
    wr_arm    = ctrl_wr_en && ctrl_addr == 8'h00 && ctrl_wdata[NT-1:0] != 0;
    ns = m_state;
    if (m_state == 2) begin
      if (ctrl_wr_en && ctrl_addr == 8'h03 && ctrl_wdata == 64'd0) ns = (m_sen != 0) ? 0 : 1;
    end else if (pc_valid && instr == WFI) ns = 2;
    else if (wr_force1) ns = 1;
    else if (wr_force2) ns = 0;
    else if (wr_arm && m_state == 1) ns = 0;
    else if (m_state == 1 && eh) ns = 0;
    else if (m_state == 0 && sh) ns = 1;
    for (int i = 0; i < NT; i++) begin
      if (ctrl_wr_en && ctrl_addr[7:4] == 4'h5 && ctrl_addr[3:0] == 4'(i)) m_hits[i] = 64'd0;
      else if (pc_valid && m_sen[i] && pc == m_sa[i] && m_state != 2 && m_hits[i] < 64'hFFFF_FFFF)
        m_hits[i] = m_hits[i] + 64'd1;
    end
    if (ctrl_wr_en && ctrl_addr == 8'h04) m_cnt = ctrl_wdata;
    else if (m_state != 2) m_cnt = m_cnt + 64'd1;
    if (ctrl_wr_en) m_write(ctrl_addr, ctrl_wdata);
    if (ctrl_rd_en) m_rdata = rv;
    m_state = ns;
    @(posedge clk);
    #1;
    chk({tag, ".state"}, 64'(trace_state), 64'(m_state));
    chk({tag, ".wfi"}, 64'(wfi_stopped), (m_state == 2) ? 64'd1 : 64'd0);
    chk({tag, ".counter"}, clk_counter, m_cnt);
    chk({tag, ".rdata"}, ctrl_rdata, m_rdata);
  endtask

  task automatic wreg(input logic [7:0] a, input logic [63:0] d);
    drive(1'b0, 64'd0, NOP, 1'b1, 1'b0, a, d);
    tick("write");
  endtask

  task automatic rreg(input logic [7:0] a);
    drive(1'b0, 64'd0, NOP, 1'b0, 1'b1, a, 64'd0);
    tick("read");
  endtask

  task automatic feed(input string tag, input logic [63:0] p, input logic [31:0] ins,
                      input logic exp_acc, input int exp_state);
    drive(1'b1, p, ins, 1'b0, 1'b0, 8'h00, 64'd0);
    #1;
    chk({tag, ".acc_k"}, 64'(trace_accept), 64'(exp_acc));
    tick(tag);
    chk({tag, ".state_k"}, 64'(trace_state), 64'(exp_state));
  endtask

  logic [63:0] saved;
  logic [63:0] pool [8];

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_sa[i] = '0; m_ea[i] = '0; m_lo[i] = '0; m_hi[i] = '0; m_hits[i] = '0;
    end
    rst = 1'b1;
    drive(1'b0, 64'd0, NOP, 1'b0, 1'b0, 8'h00, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.state", 64'(trace_state), 64'd1);
    chk("reset.wfi", 64'(wfi_stopped), 64'd0);
    chk("reset.counter", clk_counter, 64'd0);
    chk("reset.rdata", ctrl_rdata, 64'd0);
    chk("reset.accept", 64'(trace_accept), 64'd0);
    rst = 1'b0;

    // No configuration: everything traced
    for (int k = 0; k < 3; k++) feed("noconf", 64'h1000 + 64'(4 * k), NOP, 1'b1, 1);
    chk("noconf.counter3", clk_counter, 64'd3);

    // Start/end window
    wreg(8'h00, 64'b0010);
    wreg(8'h11, 64'h8000_1000);
    wreg(8'h01, 64'b0001);
    wreg(8'h20, 64'h8000_2000);
    chk("arm.state", 64'(trace_state), 64'd0);
    feed("win0", 64'h8000_0FFC, NOP, 1'b0, 0);
    feed("win1", 64'h8000_1000, NOP, 1'b1, 1);
    feed("win2", 64'h8000_1004, NOP, 1'b1, 1);
    feed("win3", 64'h8000_2000, NOP, 1'b1, 0);
    feed("win4", 64'h8000_2004, NOP, 1'b0, 0);

    // Range gate
    wreg(8'h05, 64'd1);
    wreg(8'h30, 64'h100);
    wreg(8'h40, 64'h1FF);
    wreg(8'h02, 64'd1);
    feed("rng0", 64'hFF, NOP, 1'b0, 1);
    feed("rng1", 64'h100, NOP, 1'b1, 1);
    feed("rng2", 64'h1FF, NOP, 1'b1, 1);
    feed("rng3", 64'h200, NOP, 1'b0, 1);
    wreg(8'h30, 64'h300);
    wreg(8'h40, 64'h200);
    feed("inv0", 64'hFF, NOP, 1'b0, 1);
    feed("inv1", 64'h100, NOP, 1'b0, 1);
    feed("inv2", 64'h200, NOP, 1'b0, 1);
    feed("inv3", 64'h300, NOP, 1'b0, 1);
    wreg(8'h02, 64'd0);

    // WFI halt and release
    wreg(8'h00, 64'd0);
    feed("wfi", 64'h400, WFI, 1'b1, 2);
    chk("wfi.stopped", 64'(wfi_stopped), 64'd1);
    saved = clk_counter;
    feed("wfi_blocked", 64'h404, NOP, 1'b0, 2);
    rreg(8'h03);
    chk("wfi.read", ctrl_rdata, 64'd1);
    chk("wfi.frozen", clk_counter, saved);
    wreg(8'h03, 64'd0);
    chk("wfi.release", 64'(trace_state), 64'd1);
    drive(1'b0, 64'd0, NOP, 1'b0, 1'b0, 8'h00, 64'd0);
    tick("idle");
    chk("wfi.resume", clk_counter, saved + 64'd1);

    // Simultaneous start/end, then FORCE against an end hit
    wreg(8'h00, 64'd1);
    wreg(8'h01, 64'd1);
    wreg(8'h10, 64'h700);
    wreg(8'h20, 64'h700);
    wreg(8'h05, 64'd1);
    feed("both", 64'h700, NOP, 1'b1, 0);
    wreg(8'h05, 64'd1);
    drive(1'b1, 64'h700, NOP, 1'b1, 1'b0, 8'h05, 64'd1);
    tick("force_vs_end");
    chk("force_vs_end.k", 64'(trace_state), 64'd1);

    // Counter wrap
    wreg(8'h04, 64'hFFFF_FFFF_FFFF_FFFE);
    drive(1'b0, 64'd0, NOP, 1'b0, 1'b0, 8'h00, 64'd0);
    tick("wrap1");
    tick("wrap2");
    chk("counter.wrap", clk_counter, 64'd0);

    // Start-hit counter for trigger 2
    wreg(8'h00, 64'b0100);
    wreg(8'h12, 64'hA00);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 64'hA00, NOP, 1'b0, 1'b0, 8'h00, 64'd0);
      tick("hit");
    end
    rreg(8'h52);
`ifdef CMS_TRIGGER_HIT_COUNT_EN
    chk("hitcnt.five", ctrl_rdata, 64'd5);
`else
    chk("hitcnt.absent", ctrl_rdata, 64'd0);
`endif
    wreg(8'h52, 64'h1234);
    rreg(8'h52);
    chk("hitcnt.clear", ctrl_rdata, 64'd0);

    // Readback and unmapped addresses
    rreg(8'h11);
    chk("read.start1", ctrl_rdata, 64'h8000_1000);
    rreg(8'h14);
    chk("read.idx_oob", ctrl_rdata, 64'd0);
    rreg(8'h60);
    chk("read.unmapped", ctrl_rdata, 64'd0);

    // Randomised traffic against the model
    for (int k = 0; k < 8; k++) pool[k] = 64'h2000 + 64'(16 * k);
    for (int r = 0; r < 4; r++) begin
      wreg(8'h00, 64'($urandom_range(15)));
      wreg(8'h01, 64'($urandom_range(15)));
      wreg(8'h02, 64'($urandom_range(3)));
      for (int i = 0; i < NT; i++) begin
        wreg(8'h10 + 8'(i), pool[$urandom_range(7)]);
        wreg(8'h20 + 8'(i), pool[$urandom_range(7)]);
      end
      for (int i = 0; i < NR; i++) begin
        wreg(8'h30 + 8'(i), pool[$urandom_range(7)]);
        wreg(8'h40 + 8'(i), pool[$urandom_range(7)]);
      end
      for (int n = 0; n < 150; n++) begin
        logic       v, w, rd;
        logic [7:0] a;
        logic [63:0] d;
        logic [31:0] ins;
        v   = $urandom_range(3) != 0;
        ins = ($urandom_range(15) == 0) ? WFI : NOP;
        w   = $urandom_range(9) == 0;
        rd  = $urandom_range(2) == 0;
        a   = {4'($urandom_range(5)), 4'($urandom_range(4))};
        d   = 64'd0;
        if (m_state == 2 && $urandom_range(3) == 0) begin
          drive(1'b0, 64'd0, NOP, 1'b1, rd, 8'h03, 64'd0);
        end else begin
          if (w) begin
            ins = NOP;
            if ($urandom_range(1) == 0) begin a = 8'h05; d = 64'($urandom_range(3)); end
            else begin a = 8'h00; d = 64'($urandom_range(15)); end
          end
          drive(v, pool[$urandom_range(7)], ins, w, rd, a, d);
        end
        tick("rnd");
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
